// File: rtl/axis_pixel_ingress_pkg.sv
// Shared definitions for the pixel ingress path: FSM state encoding and default
// stream/pixel/frame geometry (28x28 8-bit image fed from a 32-bit AXI4-Stream).
package axis_pixel_ingress_pkg;

    localparam int unsigned DefWidth       = 8;
    localparam int unsigned DefAxisWidth   = 32;
    localparam int unsigned DefFramePixels = 784;

    typedef enum logic [1:0] {
        StAccept = 2'd0,
        StUnpack = 2'd1,
        StDrain  = 2'd2
    } state_e;

endpackage

// File: rtl/axis_pixel_ingress_if.sv
// AXI4-Stream beat channel (no TKEEP/TSTRB; every beat is fully populated).
//   master: drives tdata/tvalid/tlast, samples tready
//   slave : samples tdata/tvalid/tlast, drives tready
interface axis_pixel_ingress_if
    import axis_pixel_ingress_pkg::*;
#(
    parameter int unsigned AXIS_WIDTH = DefAxisWidth
);
    logic [AXIS_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pixel_ingress_pixel_unpacker.sv
// Holds one captured stream beat and walks its pixel lanes, lane 0 (LSBs) first.
//   clk, rst   : clock, async active-high reset
//   load       : capture load_data/load_last and restart at lane 0
//   load_data  : beat payload, load_last: beat carried TLAST
//   advance    : current lane consumed, step to the next one
//   pixel      : current lane, driven from the registered beat (stable while stalled)
//   last_lane  : current lane is the final lane of the beat
//   beat_last  : TLAST of the held beat
module pixel_unpacker
    import axis_pixel_ingress_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned AXIS_WIDTH = DefAxisWidth,
    localparam int unsigned PPB       = AXIS_WIDTH / WIDTH,
    localparam int unsigned LW        = (PPB > 1) ? $clog2(PPB) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [AXIS_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  advance,
    output logic [WIDTH-1:0]      pixel,
    output logic                  last_lane,
    output logic                  beat_last
);
    logic [AXIS_WIDTH-1:0] beat_q;
    logic                  last_q;
    logic [LW-1:0]         lane_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            last_q <= 1'b0;
            lane_q <= '0;
        end else if (load) begin
            beat_q <= load_data;
            last_q <= load_last;
            lane_q <= '0;
        end else if (advance && !last_lane) begin
            // Parks on the final lane; only a new load returns to lane 0.
            lane_q <= lane_q + 1'b1;
        end
    end

    assign last_lane = (lane_q == LW'(PPB - 1));
    assign beat_last = last_q;
    assign pixel     = beat_q[int'(lane_q) * WIDTH +: WIDTH];
endmodule

// File: rtl/axis_pixel_ingress.sv
// Feeds the pixel FIFO from the DMA stream: one beat is accepted, then its pixels are
// written one per cycle while the FIFO has room. Frame length is checked against TLAST.
//   clk, rst        : clock, async active-high reset (FIFO shares the same reset)
//   s_axis          : AXI4-Stream slave (tdata/tvalid/tlast in, tready out)
//   o_fifo_w_stb    : FIFO write strobe, o_fifo_w_data: pixel written
//   i_fifo_full     : FIFO full, stalls unpacking without losing pixels
//   o_frame_done    : 1-cycle pulse after a correctly framed image is fully written
//   o_err_early     : sticky, TLAST arrived before FRAME_PIXELS pixels
//   o_err_late      : sticky, FRAME_PIXELS reached without TLAST
//   i_err_clear     : synchronous clear of both sticky flags (a same-cycle set wins)
//   o_pixel_count   : pixels written so far in the current frame
module axis_pixel_ingress
    import axis_pixel_ingress_pkg::*;
#(
    parameter int unsigned WIDTH        = DefWidth,
    parameter int unsigned AXIS_WIDTH   = DefAxisWidth,
    parameter int unsigned FRAME_PIXELS = DefFramePixels,
    localparam int unsigned PPB         = AXIS_WIDTH / WIDTH,
    localparam int unsigned CW          = $clog2(FRAME_PIXELS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_pixel_ingress_if.slave   s_axis,
    output logic                  o_fifo_w_stb,
    output logic [WIDTH-1:0]      o_fifo_w_data,
    input  logic                  i_fifo_full,
    output logic                  o_frame_done,
    output logic                  o_err_early,
    output logic                  o_err_late,
    input  logic                  i_err_clear,
    output logic [CW-1:0]         o_pixel_count
);
    if (AXIS_WIDTH % WIDTH != 0) begin : g_bad_width
        $error("AXIS_WIDTH must be a multiple of WIDTH");
    end
    if (FRAME_PIXELS % PPB != 0) begin : g_bad_frame
        $error("FRAME_PIXELS must be a multiple of pixels per beat");
    end

    localparam logic [CW-1:0] FrameMax = CW'(FRAME_PIXELS);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d, count_n;
    logic          frame_done_q, frame_done_d;
    logic          err_early_q, err_late_q;
    logic          early_set, late_set;
    logic          load, stb, last_lane, beat_last;

    assign load = (state_q == StAccept) && s_axis.tvalid;
    assign stb  = (state_q == StUnpack) && !i_fifo_full;

    pixel_unpacker #(
        .WIDTH      (WIDTH),
        .AXIS_WIDTH (AXIS_WIDTH)
    ) u_unpacker (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (s_axis.tdata),
        .load_last  (s_axis.tlast),
        .advance    (stb),
        .pixel      (o_fifo_w_data),
        .last_lane  (last_lane),
        .beat_last  (beat_last)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        count_n      = count_q + 1'b1;
        frame_done_d = 1'b0;
        early_set    = 1'b0;
        late_set     = 1'b0;
        unique case (state_q)
            StAccept: begin
                if (s_axis.tvalid) state_d = StUnpack;
            end
            StUnpack: begin
                if (stb) begin
                    count_d = count_n;
                    if (last_lane) begin
                        // Frame length is a whole number of beats, so the limit can
                        // only be hit on a beat boundary.
                        if (count_n == FrameMax) begin
                            count_d = '0;
                            if (beat_last) begin
                                frame_done_d = 1'b1;
                                state_d      = StAccept;
                            end else begin
                                late_set = 1'b1;
                                state_d  = StDrain;
                            end
                        end else begin
                            if (beat_last) begin
                                early_set = 1'b1;
                                count_d   = '0;
                            end
                            state_d = StAccept;
                        end
                    end
                end
            end
            StDrain: begin
                // Discard the remainder of an over-long frame up to its TLAST.
                if (s_axis.tvalid && s_axis.tlast) state_d = StAccept;
            end
            default: state_d = StAccept;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StAccept;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            err_early_q  <= 1'b0;
            err_late_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
            err_early_q  <= early_set | (err_early_q & ~i_err_clear);
            err_late_q   <= late_set | (err_late_q & ~i_err_clear);
        end
    end

    assign s_axis.tready = (state_q != StUnpack);
    assign o_fifo_w_stb  = stb;
    assign o_frame_done  = frame_done_q;
    assign o_err_early   = err_early_q;
    assign o_err_late    = err_late_q;
    assign o_pixel_count = count_q;
endmodule

// File: tb/tb_axis_pixel_ingress.sv
// Directed bench for axis_pixel_ingress with WIDTH=8, AXIS_WIDTH=32, FRAME_PIXELS=8.
// Each table row is one clock cycle: inputs are applied just after a rising edge and
// all outputs are compared at the following falling edge.
module tb_axis_pixel_ingress;
    logic       clk = 1'b0;
    logic       rst;
    logic       o_fifo_w_stb;
    logic [7:0] o_fifo_w_data;
    logic       i_fifo_full;
    logic       o_frame_done;
    logic       o_err_early;
    logic       o_err_late;
    logic       i_err_clear;
    logic [3:0] o_pixel_count;

    axis_pixel_ingress_if #(.AXIS_WIDTH(32)) s_axis ();

    axis_pixel_ingress #(
        .WIDTH        (8),
        .AXIS_WIDTH   (32),
        .FRAME_PIXELS (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis        (s_axis),
        .o_fifo_w_stb  (o_fifo_w_stb),
        .o_fifo_w_data (o_fifo_w_data),
        .i_fifo_full   (i_fifo_full),
        .o_frame_done  (o_frame_done),
        .o_err_early   (o_err_early),
        .o_err_late    (o_err_late),
        .i_err_clear   (i_err_clear),
        .o_pixel_count (o_pixel_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        full;
        logic        clr;
        logic        tready;
        logic        stb;
        logic        chkd;
        logic [7:0]  pix;
        logic        done;
        logic        ee;
        logic        el;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   wr_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Idle/accept/drain-type cycle: tready high, no write.
    task automatic acc(input logic v, input logic [31:0] d, input logic l, input logic done,
                       input logic ee, input logic el, input logic [3:0] cnt,
                       input logic clr = 1'b0);
        tbl.push_back('{v, d, l, 1'b0, clr, 1'b1, 1'b0, 1'b0, 8'h00, done, ee, el, cnt});
    endtask

    // Unpack cycle with a FIFO write of pixel p.
    task automatic px(input logic [7:0] p, input logic [3:0] cnt, input logic ee,
                      input logic el, input logic clr = 1'b0);
        tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b0, clr, 1'b0, 1'b1, 1'b1, p, 1'b0, ee, el, cnt});
    endtask

    // Unpack cycle stalled by FIFO full: no write, pixel p held.
    task automatic stall(input logic [7:0] p, input logic [3:0] cnt, input logic ee,
                         input logic el);
        tbl.push_back('{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, p, 1'b0, ee, el, cnt});
    endtask

    task automatic step(input vec_t v, input int idx);
        s_axis.tvalid = v.valid;
        s_axis.tdata  = v.data;
        s_axis.tlast  = v.last;
        i_fifo_full   = v.full;
        i_err_clear   = v.clr;
        @(negedge clk);
        chk($sformatf("row%0d.tready", idx), 32'(s_axis.tready), 32'(v.tready));
        chk($sformatf("row%0d.stb", idx), 32'(o_fifo_w_stb), 32'(v.stb));
        if (v.chkd) chk($sformatf("row%0d.data", idx), 32'(o_fifo_w_data), 32'(v.pix));
        chk($sformatf("row%0d.frame_done", idx), 32'(o_frame_done), 32'(v.done));
        chk($sformatf("row%0d.err_early", idx), 32'(o_err_early), 32'(v.ee));
        chk($sformatf("row%0d.err_late", idx), 32'(o_err_late), 32'(v.el));
        chk($sformatf("row%0d.count", idx), 32'(o_pixel_count), 32'(v.cnt));
        if (o_fifo_w_stb) wr_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int split;
        rst           = 1'b1;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        i_fifo_full   = 1'b0;
        i_err_clear   = 1'b0;

        // Phase A: well-formed frame, stalled frame, short frame, long frame.
        acc(1, 32'h04030201, 0, 0, 0, 0, 0);
        px(8'h01, 0, 0, 0); px(8'h02, 1, 0, 0); px(8'h03, 2, 0, 0); px(8'h04, 3, 0, 0);
        acc(1, 32'h08070605, 1, 0, 0, 0, 4);
        px(8'h05, 4, 0, 0); px(8'h06, 5, 0, 0); px(8'h07, 6, 0, 0); px(8'h08, 7, 0, 0);
        acc(0, 32'h0, 0, 1, 0, 0, 0);

        acc(1, 32'h04030201, 0, 0, 0, 0, 0);
        px(8'h01, 0, 0, 0); px(8'h02, 1, 0, 0);
        for (int i = 0; i < 5; i++) stall(8'h03, 2, 0, 0);
        px(8'h03, 2, 0, 0); px(8'h04, 3, 0, 0);
        acc(1, 32'h08070605, 1, 0, 0, 0, 4);
        px(8'h05, 4, 0, 0); px(8'h06, 5, 0, 0); px(8'h07, 6, 0, 0); px(8'h08, 7, 0, 0);
        acc(0, 32'h0, 0, 1, 0, 0, 0);

        acc(1, 32'h0D0C0B0A, 1, 0, 0, 0, 0);
        px(8'h0A, 0, 0, 0); px(8'h0B, 1, 0, 0); px(8'h0C, 2, 0, 0); px(8'h0D, 3, 0, 0);
        acc(1, 32'h04030201, 0, 0, 1, 0, 0);
        px(8'h01, 0, 1, 0); px(8'h02, 1, 1, 0); px(8'h03, 2, 1, 0); px(8'h04, 3, 1, 0);
        acc(1, 32'h08070605, 1, 0, 1, 0, 4);
        px(8'h05, 4, 1, 0); px(8'h06, 5, 1, 0); px(8'h07, 6, 1, 0); px(8'h08, 7, 1, 0);
        acc(0, 32'h0, 0, 1, 1, 0, 0);

        acc(1, 32'h04030201, 0, 0, 1, 0, 0);
        px(8'h01, 0, 1, 0); px(8'h02, 1, 1, 0); px(8'h03, 2, 1, 0); px(8'h04, 3, 1, 0);
        acc(1, 32'h08070605, 0, 0, 1, 0, 4);
        px(8'h05, 4, 1, 0); px(8'h06, 5, 1, 0); px(8'h07, 6, 1, 0); px(8'h08, 7, 1, 0);
        acc(1, 32'h0C0B0A09, 1, 0, 1, 1, 0);
        acc(1, 32'h04030201, 0, 0, 1, 1, 0);
        px(8'h01, 0, 1, 1); px(8'h02, 1, 1, 1);
        split = tbl.size();

        // Phase B (after mid-beat reset): clean frame, then clear racing an early TLAST.
        acc(1, 32'h04030201, 0, 0, 0, 0, 0);
        px(8'h01, 0, 0, 0); px(8'h02, 1, 0, 0); px(8'h03, 2, 0, 0); px(8'h04, 3, 0, 0);
        acc(1, 32'h08070605, 1, 0, 0, 0, 4);
        px(8'h05, 4, 0, 0); px(8'h06, 5, 0, 0); px(8'h07, 6, 0, 0); px(8'h08, 7, 0, 0);
        acc(0, 32'h0, 0, 1, 0, 0, 0);
        acc(1, 32'h0D0C0B0A, 1, 0, 0, 0, 0);
        px(8'h0A, 0, 0, 0); px(8'h0B, 1, 0, 0); px(8'h0C, 2, 0, 0);
        px(8'h0D, 3, 0, 0, 1'b1);
        acc(0, 32'h0, 0, 0, 1, 0, 0, 1'b1);
        acc(0, 32'h0, 0, 0, 0, 0, 0);

        // Reset values while reset is held.
        #3;
        chk("reset.tready", 32'(s_axis.tready), 32'd1);
        chk("reset.stb", 32'(o_fifo_w_stb), 32'd0);
        chk("reset.frame_done", 32'(o_frame_done), 32'd0);
        chk("reset.errors", {o_err_early, o_err_late}, 32'd0);
        chk("reset.count", 32'(o_pixel_count), 32'd0);
        #9;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < split; i++) step(tbl[i], i);
        chk("phaseA.writes", wr_cnt, 32'd38);

        // Mid-beat asynchronous reset: lane 2 pending, both sticky flags set.
        #1;
        chk("prerst.stb", 32'(o_fifo_w_stb), 32'd1);
        chk("prerst.data", 32'(o_fifo_w_data), 32'h03);
        chk("prerst.count", 32'(o_pixel_count), 32'd2);
        chk("prerst.errors", {o_err_early, o_err_late}, 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("asyncrst.stb", 32'(o_fifo_w_stb), 32'd0);
        chk("asyncrst.frame_done", 32'(o_frame_done), 32'd0);
        chk("asyncrst.err_early", 32'(o_err_early), 32'd0);
        chk("asyncrst.err_late", 32'(o_err_late), 32'd0);
        chk("asyncrst.count", 32'(o_pixel_count), 32'd0);
        chk("asyncrst.tready", 32'(s_axis.tready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        wr_cnt = 0;
        for (int i = split; i < tbl.size(); i++) step(tbl[i], i);
        chk("phaseB.writes", wr_cnt, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
